// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e      : sequencer states (IDLE / FLUSH / STALL)
//   flush_mask_t : per-register flush strobes, bit0=IF/ID, bit1=ID/EX, bit2=EX/MEM
//   event_e      : arbitrated request kind; the encoding order is the priority order
//   pick_event   : fixed-priority arbiter (exception > branch > load-use)
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_STALL = 2'd2
  } state_e;

  typedef logic [2:0] flush_mask_t;

  localparam flush_mask_t MASK_EXC   = 3'b111;
  localparam flush_mask_t MASK_BR    = 3'b011;
  localparam flush_mask_t MASK_STALL = 3'b010;

  // Higher encoding wins.
  typedef enum logic [1:0] {
    EV_NONE     = 2'd0,
    EV_LOAD_USE = 2'd1,
    EV_BRANCH   = 2'd2,
    EV_EXC      = 2'd3
  } event_e;

  function automatic event_e pick_event(input logic exc, input logic br, input logic lu);
    event_e ev;
    if (exc)     ev = EV_EXC;
    else if (br) ev = EV_BRANCH;
    else if (lu) ev = EV_LOAD_USE;
    else         ev = EV_NONE;
    return ev;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hold_counter.sv
// hold_counter: 4-bit down counter shared by the FLUSH and STALL hold periods.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (count cleared)
//   load     : load load_val on the next edge
//   load_val : hold length minus one
//   zero     : the count reaches 0 on the next edge (count is 1) or is already 0
module hold_counter
  import pipe_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != 4'd0) begin
      r_count <= r_count - 4'd1;
    end
  end

  // Flagged one cycle early so the sequencer leaves its hold state on the
  // same edge that the count reaches 0.
  assign zero = (r_count <= 4'd1);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central flush/stall sequencer for the 5-stage core.
//   clock, reset         : clock and asynchronous active-low reset
//   exception/exc_vector : MEM-stage exception and handler address
//   branch_taken/target  : EX-stage taken branch and redirect address
//   load_use             : ID-stage load-use hazard
//   pc_write_en, pc_sel, pc_redirect : PC control
//   ifid_write_en        : IF/ID write enable
//   ifid/idex/exmem_flush: per-register bubble strobes
//   busy                 : sequencer outside IDLE
//   flush_count          : saturating count of accepted exception/branch events
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exception,
  input  logic [XLEN-1:0]  exc_vector,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             load_use,
  output logic             pc_write_en,
  output logic             pc_sel,
  output logic [XLEN-1:0]  pc_redirect,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             busy,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);
  // A one-cycle hold is fully covered by the combinational response.
  localparam bit FLUSH_HOLD = (FLUSH_CYCLES > 1);
  localparam bit STALL_HOLD = (STALL_CYCLES > 1);

  state_e           r_state;
  flush_mask_t      r_mask;
  logic [CNT_W-1:0] r_flush_count;

  event_e           w_event;
  flush_mask_t      w_mask;
  logic             w_pc_we;
  logic             w_ifid_we;
  logic             w_pc_sel;
  logic [XLEN-1:0]  w_redirect;
  logic             w_load;
  logic [3:0]       w_load_val;
  logic             w_zero;

  // Which request is accepted in the current state; FLUSH ignores branch and
  // load-use (wrong path), STALL ignores a fresh load-use.
  always_comb begin
    w_event = EV_NONE;
    case (r_state)
      S_IDLE:  w_event = pick_event(exception, branch_taken, load_use);
      S_FLUSH: w_event = exception ? EV_EXC : EV_NONE;
      S_STALL: w_event = pick_event(exception, branch_taken, 1'b0);
      default: w_event = EV_NONE;
    endcase
  end

  // Output mux: held state first, then an accepted request overrides it.
  always_comb begin
    w_pc_we    = 1'b1;
    w_ifid_we  = 1'b1;
    w_pc_sel   = 1'b0;
    w_redirect = '0;
    w_mask     = '0;
    case (r_state)
      S_FLUSH: w_mask = r_mask;
      S_STALL: begin
        w_pc_we   = 1'b0;
        w_ifid_we = 1'b0;
        w_mask    = MASK_STALL;
      end
      default: ;
    endcase
    case (w_event)
      EV_EXC: begin
        w_pc_we    = 1'b1;
        w_ifid_we  = 1'b1;
        w_pc_sel   = 1'b1;
        w_redirect = exc_vector;
        w_mask     = MASK_EXC;
      end
      EV_BRANCH: begin
        w_pc_we    = 1'b1;
        w_ifid_we  = 1'b1;
        w_pc_sel   = 1'b1;
        w_redirect = branch_target;
        w_mask     = MASK_BR;
      end
      EV_LOAD_USE: begin
        w_pc_we   = 1'b0;
        w_ifid_we = 1'b0;
        w_mask    = MASK_STALL;
      end
      default: ;
    endcase
    // Reset bubbles every register and freezes the front end immediately.
    if (!reset) begin
      w_pc_we    = 1'b0;
      w_ifid_we  = 1'b0;
      w_pc_sel   = 1'b0;
      w_redirect = '0;
      w_mask     = MASK_EXC;
    end
  end

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (w_event)
      EV_EXC, EV_BRANCH: begin
        w_load     = FLUSH_HOLD;
        w_load_val = FLUSH_RELOAD;
      end
      EV_LOAD_USE: begin
        w_load     = STALL_HOLD;
        w_load_val = STALL_RELOAD;
      end
      default: ;
    endcase
  end

  hold_counter u_hold_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_mask        <= '0;
      r_flush_count <= '0;
    end else begin
      case (w_event)
        EV_EXC, EV_BRANCH: begin
          if (FLUSH_HOLD) begin
            r_state <= S_FLUSH;
            r_mask  <= (w_event == EV_EXC) ? MASK_EXC : MASK_BR;
          end else begin
            r_state <= S_IDLE;
            r_mask  <= '0;
          end
        end
        EV_LOAD_USE: begin
          r_state <= STALL_HOLD ? S_STALL : S_IDLE;
          r_mask  <= '0;
        end
        default: begin
          if ((r_state != S_IDLE) && w_zero) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
          end
        end
      endcase
      if (((w_event == EV_EXC) || (w_event == EV_BRANCH)) && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign pc_write_en   = w_pc_we;
  assign ifid_write_en = w_ifid_we;
  assign pc_sel        = w_pc_sel;
  assign pc_redirect   = w_redirect;
  assign ifid_flush    = w_mask[0];
  assign idex_flush    = w_mask[1];
  assign exmem_flush   = w_mask[2];
  assign busy          = (r_state != S_IDLE);
  assign flush_count   = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. Two instances share the stimulus:
// dut0 uses FLUSH_CYCLES=2/STALL_CYCLES=1, dut1 uses FLUSH_CYCLES=1/STALL_CYCLES=3.
module tb_pipeline_hazard_ctrl;

  localparam int FC0 = 2;
  localparam int SC0 = 1;
  localparam int FC1 = 1;
  localparam int SC1 = 3;

  typedef struct packed {
    logic        pc_we;
    logic        pc_sel;
    logic        ifid_we;
    logic [2:0]  fl;      // {exmem, idex, ifid}
    logic        busy;
    logic [31:0] redir;
    logic [7:0]  cnt;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        exception;
  logic [31:0] exc_vector;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        load_use;

  logic        pc_we0, pc_sel0, ifid_we0, ifid_fl0, idex_fl0, exmem_fl0, busy0;
  logic [31:0] redir0;
  logic [7:0]  cnt0;
  logic        pc_we1, pc_sel1, ifid_we1, ifid_fl1, idex_fl1, exmem_fl1, busy1;
  logic [31:0] redir1;
  logic [7:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t x0;
  exp_t x1;

  // Reference model state per instance: kind 0=idle 1=flush 2=stall,
  // left = held cycles remaining after the current one.
  int          m_kind[2];
  int          m_left[2];
  logic [2:0]  m_mask[2];
  int          m_cnt[2];
  int          m_fc[2];
  int          m_sc[2];

  pipeline_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC0), .STALL_CYCLES(SC0), .CNT_W(8)) dut0 (
    .clock(clock), .reset(reset), .exception(exception), .exc_vector(exc_vector),
    .branch_taken(branch_taken), .branch_target(branch_target), .load_use(load_use),
    .pc_write_en(pc_we0), .pc_sel(pc_sel0), .pc_redirect(redir0), .ifid_write_en(ifid_we0),
    .ifid_flush(ifid_fl0), .idex_flush(idex_fl0), .exmem_flush(exmem_fl0), .busy(busy0),
    .flush_count(cnt0)
  );

  pipeline_hazard_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC1), .STALL_CYCLES(SC1), .CNT_W(8)) dut1 (
    .clock(clock), .reset(reset), .exception(exception), .exc_vector(exc_vector),
    .branch_taken(branch_taken), .branch_target(branch_target), .load_use(load_use),
    .pc_write_en(pc_we1), .pc_sel(pc_sel1), .pc_redirect(redir1), .ifid_write_en(ifid_we1),
    .ifid_flush(ifid_fl1), .idex_flush(idex_fl1), .exmem_flush(exmem_fl1), .busy(busy1),
    .flush_count(cnt1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic accept_flush(input int d, input logic [2:0] mask, input logic [31:0] addr,
                              inout exp_t x);
    x.pc_we   = 1'b1;
    x.ifid_we = 1'b1;
    x.pc_sel  = 1'b1;
    x.redir   = addr;
    x.fl      = mask;
    if (m_cnt[d] < 255) m_cnt[d]++;
    if (m_fc[d] > 1) begin
      m_kind[d] = 1;
      m_left[d] = m_fc[d] - 1;
      m_mask[d] = mask;
    end else begin
      m_kind[d] = 0;
      m_left[d] = 0;
    end
  endtask

  task automatic model(input int d, input logic r, input logic e, input logic [31:0] v,
                       input logic b, input logic [31:0] t, input logic l, output exp_t x);
    x = '0;
    if (!r) begin
      x.fl      = 3'b111;
      m_kind[d] = 0;
      m_left[d] = 0;
      m_mask[d] = 3'b000;
      m_cnt[d]  = 0;
    end else begin
      x.pc_we   = 1'b1;
      x.ifid_we = 1'b1;
      x.busy    = (m_kind[d] != 0);
      x.cnt     = 8'(m_cnt[d]);
      if (m_kind[d] == 1) x.fl = m_mask[d];
      if (m_kind[d] == 2) begin
        x.pc_we   = 1'b0;
        x.ifid_we = 1'b0;
        x.fl      = 3'b010;
      end
      if (e) begin
        accept_flush(d, 3'b111, v, x);
      end else if (b && m_kind[d] != 1) begin
        accept_flush(d, 3'b011, t, x);
      end else if (l && m_kind[d] == 0) begin
        x.pc_we   = 1'b0;
        x.ifid_we = 1'b0;
        x.fl      = 3'b010;
        if (m_sc[d] > 1) begin
          m_kind[d] = 2;
          m_left[d] = m_sc[d] - 1;
        end
      end else if (m_kind[d] != 0) begin
        m_left[d]--;
        if (m_left[d] <= 0) m_kind[d] = 0;
      end
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge and queue the
  // outputs both instances must show for that cycle.
  task automatic step(input logic r, input logic e, input logic [31:0] v,
                      input logic b, input logic [31:0] t, input logic l);
    exp_t xa;
    exp_t xb;
    @(posedge clock);
    #1;
    reset         = r;
    exception     = e;
    exc_vector    = v;
    branch_taken  = b;
    branch_target = t;
    load_use      = l;
    model(0, r, e, v, b, t, l, xa);
    model(1, r, e, v, b, t, l, xb);
    q0.push_back(xa);
    q1.push_back(xb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  always @(negedge clock) begin
    if (q0.size() != 0) begin
      x0 = q0.pop_front();
      check_eq("d0_ctrl", 64'({pc_we0, pc_sel0, ifid_we0, exmem_fl0, idex_fl0, ifid_fl0, busy0}),
               64'({x0.pc_we, x0.pc_sel, x0.ifid_we, x0.fl, x0.busy}));
      check_eq("d0_redirect", 64'(redir0), 64'(x0.redir));
      check_eq("d0_flush_count", 64'(cnt0), 64'(x0.cnt));
    end
    if (q1.size() != 0) begin
      x1 = q1.pop_front();
      check_eq("d1_ctrl", 64'({pc_we1, pc_sel1, ifid_we1, exmem_fl1, idex_fl1, ifid_fl1, busy1}),
               64'({x1.pc_we, x1.pc_sel, x1.ifid_we, x1.fl, x1.busy}));
      check_eq("d1_redirect", 64'(redir1), 64'(x1.redir));
      check_eq("d1_flush_count", 64'(cnt1), 64'(x1.cnt));
    end
  end

  initial begin
    m_fc[0] = FC0; m_sc[0] = SC0;
    m_fc[1] = FC1; m_sc[1] = SC1;
    for (int d = 0; d < 2; d++) begin
      m_kind[d] = 0; m_left[d] = 0; m_mask[d] = 3'b000; m_cnt[d] = 0;
    end
    reset = 1'b0; exception = 1'b0; exc_vector = '0;
    branch_taken = 1'b0; branch_target = '0; load_use = 1'b0;

    // Power-on reset, then release into IDLE defaults.
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    idle(2);

    // Taken branch to 0x40.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    idle(3);

    // Load-use pulse.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle(4);

    // All three requests together; exception wins.
    step(1'b1, 1'b1, 32'h80, 1'b1, 32'h44, 1'b1);
    idle(3);

    // Branch then exception on the following cycle.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    idle(3);

    // Stall preempted by a branch; stall with repeated load-use then exception.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1);
    idle(4);

    // Branch during a flush is ignored on dut0.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h504, 1'b1);
    idle(3);

    // Reset asserted mid-flush, then released.
    step(1'b1, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h700, 1'b1, 32'h704, 1'b1);
    idle(3);

    // Random request mix.
    for (int i = 0; i < 60; i++) begin
      step(1'b1, ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) == 0), $urandom,
           ($urandom_range(0, 2) == 0));
    end
    idle(4);

    // Enough branches to saturate the 8-bit counter.
    for (int i = 0; i < 259; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i), 1'b0);
      idle(1);
    end
    idle(2);

    @(negedge clock);
    #1;
    check_eq("d0_sat_final", 64'(cnt0), 64'hFF);
    check_eq("d1_sat_final", 64'(cnt1), 64'hFF);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
